// File: rtl/alu_writeback_pkg.sv
// Shared definitions for the ALU datapath slice: operation encodings and data width.
package alu_writeback_pkg;

  localparam int DW = 8;

  typedef enum logic [2:0] {
    OP_PASS_A   = 3'b000,
    OP_AND      = 3'b001,
    OP_OR       = 3'b010,
    OP_XOR      = 3'b011,
    OP_PASS_B   = 3'b100,
    OP_ADD      = 3'b101,
    OP_NOTA_ADD = 3'b110
  } alu_op_e;

endpackage

// File: rtl/regfile_2r1w.sv
// NREG x DW register file: two combinational read ports, one synchronous write port.
module regfile_2r1w
  import alu_writeback_pkg::*;
#(
  parameter int NREG = 4,
  parameter int SELW = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            we,
  input  logic [SELW-1:0] wsel,
  input  logic [DW-1:0]   wdata,
  input  logic [SELW-1:0] ra_sel,
  input  logic [SELW-1:0] rb_sel,
  output logic [DW-1:0]   ra,
  output logic [DW-1:0]   rb
);

  logic [DW-1:0] mem [NREG];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) mem[i] <= '0;
    end else if (we) begin
      mem[wsel] <= wdata;
    end
  end

  assign ra = mem[ra_sel];
  assign rb = mem[rb_sel];

endmodule

// File: rtl/alu_writeback.sv
// One-entry writeback stage behind the ALU: commits results to the regfile and flags,
// bypasses the pending entry back to the ALU operands and carry_in, counts retired ops.
module alu_writeback
  import alu_writeback_pkg::*;
#(
  parameter int NREG = 4,
  parameter int SELW = 2,
  parameter int CNTW = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            alu_valid,
  input  logic [DW-1:0]   alu_out,
  input  logic            alu_carry,
  input  logic [SELW-1:0] wr_sel,
  input  logic            reg_we,
  input  logic            flag_we,
  input  logic            hold,
  output logic            accept,
  input  logic [SELW-1:0] rd_a_sel,
  input  logic [SELW-1:0] rd_b_sel,
  output logic [DW-1:0]   rd_a,
  output logic [DW-1:0]   rd_b,
  output logic            carry_q,
  output logic            zero_q,
  output logic [CNTW-1:0] retired
);

  logic            vld_p1;
  logic            rwe_p1;
  logic            fwe_p1;
  logic [SELW-1:0] sel_p1;
  logic [DW-1:0]   data_p1;
  logic            carry_p1;
  logic            zero_p1;

  logic            carry_r;
  logic            zero_r;
  logic            commit;
  logic [DW-1:0]   rf_a;
  logic [DW-1:0]   rf_b;

  assign accept = alu_valid & ~hold;
  assign commit = vld_p1 & ~hold;

  // p0 -> p1: capture the ALU result into the writeback stage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1 <= 1'b0;
      rwe_p1 <= 1'b0;
      fwe_p1 <= 1'b0;
    end else if (!hold) begin
      vld_p1 <= alu_valid;
      rwe_p1 <= reg_we;
      fwe_p1 <= flag_we;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      sel_p1   <= wr_sel;
      data_p1  <= alu_out;
      carry_p1 <= alu_carry;
      zero_p1  <= (alu_out == '0);
    end
  end

  // p1 -> architectural state: commit flags, counter and regfile write
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      carry_r <= 1'b0;
      zero_r  <= 1'b0;
      retired <= '0;
    end else if (commit) begin
      retired <= retired + CNTW'(1);
      if (fwe_p1) begin
        carry_r <= carry_p1;
        zero_r  <= zero_p1;
      end
    end
  end

  regfile_2r1w #(
    .NREG (NREG),
    .SELW (SELW)
  ) u_regfile (
    .clk    (clk),
    .rst_n  (rst_n),
    .we     (commit & rwe_p1),
    .wsel   (sel_p1),
    .wdata  (data_p1),
    .ra_sel (rd_a_sel),
    .rb_sel (rd_b_sel),
    .ra     (rf_a),
    .rb     (rf_b)
  );

  // Bypass stays live during hold so stalled consumers see the pending result
  assign rd_a    = (vld_p1 && rwe_p1 && sel_p1 == rd_a_sel) ? data_p1 : rf_a;
  assign rd_b    = (vld_p1 && rwe_p1 && sel_p1 == rd_b_sel) ? data_p1 : rf_b;
  assign carry_q = (vld_p1 && fwe_p1) ? carry_p1 : carry_r;
  assign zero_q  = (vld_p1 && fwe_p1) ? zero_p1  : zero_r;

endmodule

// File: tb/tb_alu_writeback.sv
// Directed bench for alu_writeback: bypass, commit, flags, hold, counter wrap and reset discard.
module tb_alu_writeback;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        alu_valid;
  logic [7:0]  alu_out;
  logic        alu_carry;
  logic [1:0]  wr_sel;
  logic        reg_we;
  logic        flag_we;
  logic        hold;
  logic        accept;
  logic [1:0]  rd_a_sel;
  logic [1:0]  rd_b_sel;
  logic [7:0]  rd_a;
  logic [7:0]  rd_b;
  logic        carry_q;
  logic        zero_q;
  logic [15:0] retired;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  alu_writeback #(.NREG(4), .SELW(2), .CNTW(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .alu_valid (alu_valid),
    .alu_out   (alu_out),
    .alu_carry (alu_carry),
    .wr_sel    (wr_sel),
    .reg_we    (reg_we),
    .flag_we   (flag_we),
    .hold      (hold),
    .accept    (accept),
    .rd_a_sel  (rd_a_sel),
    .rd_b_sel  (rd_b_sel),
    .rd_a      (rd_a),
    .rd_b      (rd_b),
    .carry_q   (carry_q),
    .zero_q    (zero_q),
    .retired   (retired)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic present(input logic v, input logic [7:0] d, input logic c,
                         input logic [1:0] s, input logic rwe, input logic fwe);
    alu_valid = v;
    alu_out   = d;
    alu_carry = c;
    wr_sel    = s;
    reg_we    = rwe;
    flag_we   = fwe;
  endtask

  initial begin
    rst_n = 1'b0;
    hold = 1'b0;
    rd_a_sel = 2'd0;
    rd_b_sel = 2'd0;
    present(1'b0, 8'h00, 1'b0, 2'd0, 1'b0, 1'b0);
    #12;

    // Reset state on every select
    for (int i = 0; i < 4; i++) begin
      rd_a_sel = 2'(i);
      rd_b_sel = 2'(3 - i);
      #1;
      chk("rst_rd_a", 32'(rd_a), 32'h00);
      chk("rst_rd_b", 32'(rd_b), 32'h00);
    end
    chk("rst_carry", 32'(carry_q), 32'h0);
    chk("rst_zero", 32'(zero_q), 32'h0);
    chk("rst_retired", 32'(retired), 32'h0);
    chk("rst_accept", 32'(accept), 32'h0);
    rst_n = 1'b1;
    cyc();

    // Single write 0x5A to reg 2, carry input set but flags not written
    rd_a_sel = 2'd2;
    present(1'b1, 8'h5A, 1'b1, 2'd2, 1'b1, 1'b0);
    #1;
    chk("w1_accept", 32'(accept), 32'h1);
    cyc();
    present(1'b0, 8'hFF, 1'b1, 2'd0, 1'b0, 1'b0);
    #1;
    chk("w1_bypass_rd_a", 32'(rd_a), 32'h5A);
    chk("w1_retired_pending", 32'(retired), 32'h0);
    chk("w1_carry_pending", 32'(carry_q), 32'h0);
    cyc();
    chk("w1_regfile_rd_a", 32'(rd_a), 32'h5A);
    chk("w1_retired", 32'(retired), 32'h1);
    chk("w1_carry", 32'(carry_q), 32'h0);

    // Back-to-back writes to reg 1
    rd_b_sel = 2'd1;
    present(1'b1, 8'h11, 1'b0, 2'd1, 1'b1, 1'b0);
    cyc();
    present(1'b1, 8'h22, 1'b0, 2'd1, 1'b1, 1'b0);
    #1;
    chk("b2b_rd_b_first", 32'(rd_b), 32'h11);
    cyc();
    present(1'b0, 8'h00, 1'b0, 2'd0, 1'b0, 1'b0);
    #1;
    chk("b2b_rd_b_second", 32'(rd_b), 32'h22);
    cyc();
    chk("b2b_regfile", 32'(rd_b), 32'h22);
    chk("b2b_retired", 32'(retired), 32'h3);

    // Flags: zero result with carry, then nonzero without carry
    present(1'b1, 8'h00, 1'b1, 2'd0, 1'b0, 1'b1);
    cyc();
    present(1'b1, 8'h01, 1'b0, 2'd0, 1'b0, 1'b1);
    #1;
    chk("flag1_carry", 32'(carry_q), 32'h1);
    chk("flag1_zero", 32'(zero_q), 32'h1);
    cyc();
    present(1'b0, 8'h00, 1'b0, 2'd0, 1'b0, 1'b0);
    #1;
    chk("flag2_carry", 32'(carry_q), 32'h0);
    chk("flag2_zero", 32'(zero_q), 32'h0);
    cyc();
    rd_a_sel = 2'd0;
    #1;
    chk("flag_no_regwrite", 32'(rd_a), 32'h00);
    chk("flag_retired", 32'(retired), 32'h5);
    chk("flag2_carry_arch", 32'(carry_q), 32'h0);

    // Hold with a pending write to reg 3 and a new op waiting
    rd_a_sel = 2'd3;
    rd_b_sel = 2'd0;
    present(1'b1, 8'h33, 1'b0, 2'd3, 1'b1, 1'b0);
    cyc();
    hold = 1'b1;
    present(1'b1, 8'h44, 1'b0, 2'd0, 1'b1, 1'b0);
    #1;
    chk("hold_accept0", 32'(accept), 32'h0);
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("hold_accept", 32'(accept), 32'h0);
      chk("hold_rd_a_bypass", 32'(rd_a), 32'h33);
      chk("hold_rd_b", 32'(rd_b), 32'h00);
      chk("hold_retired", 32'(retired), 32'h5);
    end
    hold = 1'b0;
    #1;
    chk("unhold_accept", 32'(accept), 32'h1);
    cyc();
    present(1'b0, 8'h00, 1'b0, 2'd0, 1'b0, 1'b0);
    #1;
    chk("unhold_rd_a_reg", 32'(rd_a), 32'h33);
    chk("unhold_rd_b_bypass", 32'(rd_b), 32'h44);
    chk("unhold_retired", 32'(retired), 32'h6);
    cyc();
    chk("unhold_rd_b_reg", 32'(rd_b), 32'h44);
    chk("unhold_retired2", 32'(retired), 32'h7);

    // Counter wrap: 65528 streamed no-write ops bring retired from 7 to 0xFFFF
    present(1'b1, 8'h01, 1'b0, 2'd0, 1'b0, 1'b0);
    for (int i = 0; i < 65528; i++) cyc();
    present(1'b0, 8'h00, 1'b0, 2'd0, 1'b0, 1'b0);
    cyc();
    chk("wrap_preload", 32'(retired), 32'hFFFF);
    present(1'b1, 8'h01, 1'b0, 2'd0, 1'b0, 1'b0);
    cyc();
    present(1'b0, 8'h00, 1'b0, 2'd0, 1'b0, 1'b0);
    cyc();
    chk("wrap_zero", 32'(retired), 32'h0000);

    // Reset with a pending entry discards it
    rd_a_sel = 2'd2;
    rd_b_sel = 2'd1;
    present(1'b1, 8'h80, 1'b1, 2'd2, 1'b1, 1'b1);
    cyc();
    present(1'b0, 8'h00, 1'b0, 2'd0, 1'b0, 1'b0);
    #1;
    chk("pend_rd_a_bypass", 32'(rd_a), 32'h80);
    chk("pend_carry", 32'(carry_q), 32'h1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_rd_a", 32'(rd_a), 32'h00);
    chk("mid_rst_rd_b", 32'(rd_b), 32'h00);
    chk("mid_rst_carry", 32'(carry_q), 32'h0);
    chk("mid_rst_zero", 32'(zero_q), 32'h0);
    chk("mid_rst_retired", 32'(retired), 32'h0);
    #3;
    rst_n = 1'b1;
    cyc();
    cyc();
    chk("post_rst_rd_a", 32'(rd_a), 32'h00);
    chk("post_rst_retired", 32'(retired), 32'h0);
    rd_a_sel = 2'd3;
    rd_b_sel = 2'd0;
    #1;
    chk("post_rst_reg3", 32'(rd_a), 32'h00);
    chk("post_rst_reg0", 32'(rd_b), 32'h00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
